uart_tx_arbiter: RTL

- Shares one UART byte transmitter (start/busy interface, 115200 baud at 27 MHz) between NUM_REQ requesters, for example a debug dumper, a counter reporter and a command echo.
- Arbitration is round-robin with packet lock: once granted, a requester keeps the transmitter until it sends a byte flagged last.
- Sits between the requesters and the serializer; the serializer is unchanged.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_select.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the UART transmit arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_arb_pkg;

  // State encodings of the arbiter FSM
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] XFER    = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_XFER    = XFER,
    ST_WAIT_HI = WAIT_HI,
    ST_WAIT_LO = WAIT_LO
  } arb_state_t;

  // Serializer clocks per bit at 115200 baud from 27 MHz
  localparam int DELAY_FRAMES = 234;

  // One UART frame (10 bit times) of stall before a lock is broken
  localparam int TIMEOUT_CYCLES_DFLT = 10 * DELAY_FRAMES;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request after rr_ptr_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to act on the pick.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] rr_ptr_i,
  output logic               any_o,
  output logic [GRANT_W-1:0] idx_o
);

  // Scan from the farthest candidate back to the nearest so the nearest wins
  always_comb begin
    int                 cand;
    logic [GRANT_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    any_o    = 1'b0;
    idx_o    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand     = (int'(rr_ptr_i) + i) % NUM_REQ;
      cand_idx = cand[GRANT_W-1:0];
      if (req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART byte serializer (optional lock timeout: UART_ARB_TIMEOUT_EN).
// Latency: valid in IDLE at N -> ready at N+1 -> tx_start_o at N+2; next byte of a packet 2 cycles after tx_busy_i falls.
// Backpressure: one byte in flight; ready only to the lock owner in XFER; tx_busy_i high in IDLE blocks new grants.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GRANT_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [GRANT_W-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               timeout_q, timeout_d;

  logic               pick_any;
  logic [GRANT_W-1:0] pick_idx;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               sel_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_select (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx)
  );

  assign sel_data  = req_data_i[{grant_q, 3'b000} +: 8];
  assign sel_last  = req_last_i[grant_q];
  assign sel_valid = req_valid_i[grant_q];

  // Only the lock owner sees ready, and only while waiting for its next byte
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_XFER) begin
      req_ready_o[grant_q] = 1'b1;
    end
  end

  // Next-state and registered-output computation of the arbiter FSM
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy_i) begin
          grant_d = pick_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (sel_valid) begin
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          last_d     = sel_last;
          state_d    = ST_WAIT_HI;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          // Owner went silent too long: drop the lock, packet left unterminated
          timeout_d = 1'b1;
          rr_ptr_d  = grant_q;
          state_d   = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
`endif
      end
      ST_WAIT_HI: begin
        // Serializer raises busy one cycle after the start pulse
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy_i) begin
          if (last_q) begin
            rr_ptr_d = grant_q;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GRANT_W'(NUM_REQ - 1);
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign timeout_o  = timeout_q;

endmodule
